// File: rtl/xoseram_io_ring_pkg.sv
// Shared constants and types for the XoseRAM pad ring.
// Package name is xv; imported by the ring top.
package xv;

  // Bus pad polarities
  localparam logic CS_ENABLED = 1'b0;
  localparam logic RnW_READ   = 1'b1;

  // PLL configuration carried alongside the ring for the board build
  localparam logic [3:0] PLL_DIVR = 4'd0;
  localparam logic [6:0] PLL_DIVF = 7'd66;
  localparam logic [2:0] PLL_DIVQ = 3'd5;

  localparam int VID_BITS = 4;

  // Video pin bundle, MSB-first order {de,vs,hs,r,g,b}
  typedef struct packed {
    logic                de;
    logic                vs;
    logic                hs;
    logic [VID_BITS-1:0] r;
    logic [VID_BITS-1:0] g;
    logic [VID_BITS-1:0] b;
  } vid_pins_t;

endpackage

// File: rtl/xoseram_io_ring_ddr_out.sv
// Generic two-edge output flop: d_rise_i shows during the high phase of clk,
// d_fall_i during the low phase. Both halves clear on reset_n.
module xoseram_ddr_out (
  input  logic clk,
  input  logic reset_n,
  input  logic d_rise_i,
  input  logic d_fall_i,
  output logic q_o
);

  logic r_rise;
  logic r_fall;

  // Rising-edge half
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rise <= 1'b0;
    else          r_rise <= d_rise_i;
  end

  // Falling-edge half
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) r_fall <= 1'b0;
    else          r_fall <= d_fall_i;
  end

  // Pad mux selects the half captured on the edge that opened this phase
  assign q_o = clk ? r_rise : r_fall;

endmodule

// File: rtl/xoseram_io_ring.sv
// XoseRAM pad ring: registered m68k bus, video and IRQ pads, DDR pixel clock,
// PLL-lock-derived core reset, warm-boot latch.
// Optional feature macro: XOSERA_WARMBOOT_EN (warm-boot registers present when defined).
module xoseram_io_ring
  import xv::*;
#(
  parameter int DATA_W   = 8,
  parameter int VID_W    = VID_BITS,
  parameter int REGNUM_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pll_lock_i,
  input  logic                bus_cs_n_i,
  input  logic                bus_rd_nwr_i,
  input  logic                bus_bytesel_i,
  input  logic [REGNUM_W-1:0] bus_reg_num_i,
  input  logic [DATA_W-1:0]   bus_data_pad_i,
  output logic [DATA_W-1:0]   bus_data_pad_o,
  output logic                bus_data_oe_o,
  output logic                core_cs_n_o,
  output logic                core_rd_nwr_o,
  output logic                core_bytesel_o,
  output logic [REGNUM_W-1:0] core_reg_num_o,
  output logic [DATA_W-1:0]   core_data_o,
  input  logic [DATA_W-1:0]   core_data_i,
  input  logic [VID_W-1:0]    vid_r_i,
  input  logic [VID_W-1:0]    vid_g_i,
  input  logic [VID_W-1:0]    vid_b_i,
  input  logic                vid_hs_i,
  input  logic                vid_vs_i,
  input  logic                vid_de_i,
  output logic [VID_W-1:0]    dv_r_o,
  output logic [VID_W-1:0]    dv_g_o,
  output logic [VID_W-1:0]    dv_b_o,
  output logic                dv_hs_o,
  output logic                dv_vs_o,
  output logic                dv_de_o,
  output logic                dv_idck_o,
  input  logic                bus_intr_i,
  output logic                bus_irq_n_o,
  input  logic                reconfig_i,
  input  logic [1:0]          boot_select_i,
  output logic                warmboot_o,
  output logic [1:0]          boot_sel_o,
  output logic                core_reset_o
);

  logic                r_cs_n;
  logic                r_rd_nwr;
  logic                r_bytesel;
  logic [REGNUM_W-1:0] r_reg_num;
  logic [DATA_W-1:0]   r_data;
  vid_pins_t           r_vid;
  logic                r_irq_n;
  logic                r_core_reset;

  // Bus pad input registers; cs_n/rd_nwr idle deselected so oe drops in reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_n    <= ~CS_ENABLED;
      r_rd_nwr  <= RnW_READ;
      r_bytesel <= 1'b0;
      r_reg_num <= '0;
      r_data    <= '0;
    end else begin
      r_cs_n    <= bus_cs_n_i;
      r_rd_nwr  <= bus_rd_nwr_i;
      r_bytesel <= bus_bytesel_i;
      r_reg_num <= bus_reg_num_i;
      r_data    <= bus_data_pad_i;
    end
  end

  assign core_cs_n_o    = r_cs_n;
  assign core_rd_nwr_o  = r_rd_nwr;
  assign core_bytesel_o = r_bytesel;
  assign core_reg_num_o = r_reg_num;
  assign core_data_o    = r_data;

  // Drive the pad only for a selected read, judged from the registered copies
  assign bus_data_oe_o  = (r_cs_n == CS_ENABLED) && (r_rd_nwr == RnW_READ);
  assign bus_data_pad_o = core_data_i;

  // Video, IRQ and core-reset output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vid        <= '0;
      r_irq_n      <= 1'b0;
      r_core_reset <= 1'b1;
    end else begin
      r_vid        <= '{de: vid_de_i, vs: vid_vs_i, hs: vid_hs_i,
                        r: vid_r_i, g: vid_g_i, b: vid_b_i};
      r_irq_n      <= bus_intr_i;
      r_core_reset <= !pll_lock_i;
    end
  end

  assign dv_r_o       = r_vid.r;
  assign dv_g_o       = r_vid.g;
  assign dv_b_o       = r_vid.b;
  assign dv_hs_o      = r_vid.hs;
  assign dv_vs_o      = r_vid.vs;
  assign dv_de_o      = r_vid.de;
  assign bus_irq_n_o  = r_irq_n;
  assign core_reset_o = r_core_reset;

  // Pixel clock pad is the inverse of clk, launched from both edges
  xoseram_ddr_out u_idck (
    .clk      (clk),
    .reset_n  (reset_n),
    .d_rise_i (1'b0),
    .d_fall_i (1'b1),
    .q_o      (dv_idck_o)
  );

`ifdef XOSERA_WARMBOOT_EN
  logic       r_warmboot;
  logic [1:0] r_boot_sel;

  // Warm-boot request follows the core level, one cycle late
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_warmboot <= 1'b0;
      r_boot_sel <= 2'b00;
    end else begin
      r_warmboot <= reconfig_i;
      r_boot_sel <= boot_select_i;
    end
  end

  assign warmboot_o = r_warmboot;
  assign boot_sel_o = r_boot_sel;
`else
  // Feature absent: requests are dropped
  logic w_unused_warmboot;
  assign w_unused_warmboot = ^{reconfig_i, boot_select_i};
  assign warmboot_o        = 1'b0;
  assign boot_sel_o        = 2'b00;
`endif

endmodule

// File: tb/tb_xoseram_io_ring.sv
// Directed bench for xoseram_io_ring: vector table plus hand sequences for
// reset, PLL lock, oe timing, DDR clock phase and mid-transfer reset.
module tb_xoseram_io_ring;

`ifdef XOSERA_WARMBOOT_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_lock_i;
  logic       bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i;
  logic [3:0] bus_reg_num_i;
  logic [7:0] bus_data_pad_i, bus_data_pad_o, core_data_i, core_data_o;
  logic       bus_data_oe_o;
  logic       core_cs_n_o, core_rd_nwr_o, core_bytesel_o;
  logic [3:0] core_reg_num_o;
  logic [3:0] vid_r_i, vid_g_i, vid_b_i, dv_r_o, dv_g_o, dv_b_o;
  logic       vid_hs_i, vid_vs_i, vid_de_i, dv_hs_o, dv_vs_o, dv_de_o, dv_idck_o;
  logic       bus_intr_i, bus_irq_n_o, reconfig_i, warmboot_o, core_reset_o;
  logic [1:0] boot_select_i, boot_sel_o;

  always #5 clk = ~clk;

  xoseram_io_ring dut (
    .clk(clk), .reset_n(reset_n), .pll_lock_i(pll_lock_i),
    .bus_cs_n_i(bus_cs_n_i), .bus_rd_nwr_i(bus_rd_nwr_i), .bus_bytesel_i(bus_bytesel_i),
    .bus_reg_num_i(bus_reg_num_i), .bus_data_pad_i(bus_data_pad_i),
    .bus_data_pad_o(bus_data_pad_o), .bus_data_oe_o(bus_data_oe_o),
    .core_cs_n_o(core_cs_n_o), .core_rd_nwr_o(core_rd_nwr_o), .core_bytesel_o(core_bytesel_o),
    .core_reg_num_o(core_reg_num_o), .core_data_o(core_data_o), .core_data_i(core_data_i),
    .vid_r_i(vid_r_i), .vid_g_i(vid_g_i), .vid_b_i(vid_b_i),
    .vid_hs_i(vid_hs_i), .vid_vs_i(vid_vs_i), .vid_de_i(vid_de_i),
    .dv_r_o(dv_r_o), .dv_g_o(dv_g_o), .dv_b_o(dv_b_o),
    .dv_hs_o(dv_hs_o), .dv_vs_o(dv_vs_o), .dv_de_o(dv_de_o), .dv_idck_o(dv_idck_o),
    .bus_intr_i(bus_intr_i), .bus_irq_n_o(bus_irq_n_o),
    .reconfig_i(reconfig_i), .boot_select_i(boot_select_i),
    .warmboot_o(warmboot_o), .boot_sel_o(boot_sel_o), .core_reset_o(core_reset_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Vector: inputs then expected outputs one edge later
  typedef struct {
    logic        cs_n, rd, bs;
    logic [3:0]  reg_num;
    logic [7:0]  pad_i, cd;
    logic [14:0] vid;      // {de,vs,hs,r,g,b}
    logic        intr, rcf;
    logic [1:0]  bsel;
    logic        ex_oe;
    logic [7:0]  ex_pad;
    logic [14:0] ex_core;  // {cs_n,rd,bytesel,reg_num,data}
    logic [14:0] ex_vid;
    logic        ex_irq, ex_wb;
    logic [1:0]  ex_bsel;
  } vec_t;

  vec_t vecs[6];

  task automatic apply(input vec_t v);
    bus_cs_n_i = v.cs_n; bus_rd_nwr_i = v.rd; bus_bytesel_i = v.bs;
    bus_reg_num_i = v.reg_num; bus_data_pad_i = v.pad_i; core_data_i = v.cd;
    {vid_de_i, vid_vs_i, vid_hs_i, vid_r_i, vid_g_i, vid_b_i} = v.vid;
    bus_intr_i = v.intr; reconfig_i = v.rcf; boot_select_i = v.bsel;
  endtask

  task automatic idle();
    bus_cs_n_i = 1; bus_rd_nwr_i = 1; bus_bytesel_i = 0; bus_reg_num_i = 0;
    bus_data_pad_i = 0; core_data_i = 0;
    {vid_de_i, vid_vs_i, vid_hs_i, vid_r_i, vid_g_i, vid_b_i} = '0;
    bus_intr_i = 0; reconfig_i = 0; boot_select_i = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core"}, {core_cs_n_o, core_rd_nwr_o, core_bytesel_o, core_reg_num_o, core_data_o}, 15'h6000);
    chk({tag, "_oe"}, bus_data_oe_o, 0);
    chk({tag, "_dv"}, {dv_de_o, dv_vs_o, dv_hs_o, dv_r_o, dv_g_o, dv_b_o, dv_idck_o}, 0);
    chk({tag, "_irq"}, bus_irq_n_o, 0);
    chk({tag, "_wb"}, {warmboot_o, boot_sel_o}, 0);
    chk({tag, "_crst"}, core_reset_o, 1);
  endtask

  initial begin
    //                                      cs rd bs reg pad_i  cd    vid(de,vs,hs,r,g,b) in rc bs | oe pad  core     vid      irq wb  bsel
    vecs[0] = '{0,1,0,4'hA,8'h00,8'h5C,15'h1F18,0,0,2'd0, 1,8'h5C,15'h2A00,15'h1F18,0,0,2'd0};
    vecs[1] = '{1,1,0,4'hA,8'h00,8'h5C,15'h0000,0,0,2'd0, 0,8'h5C,15'h6A00,15'h0000,0,0,2'd0};
    vecs[2] = '{0,0,1,4'h3,8'h3E,8'hA5,15'h0123,0,0,2'd0, 0,8'hA5,15'h133E,15'h0123,0,0,2'd0};
    vecs[3] = '{0,1,0,4'hF,8'hFF,8'h81,15'h6ABC,1,1,2'd2, 1,8'h81,15'h2FFF,15'h6ABC,1,WB,WB ? 2'd2 : 2'd0};
    vecs[4] = '{1,0,1,4'h0,8'h01,8'h7E,15'h7FFF,1,1,2'd1, 0,8'h7E,15'h5001,15'h7FFF,1,WB,WB ? 2'd1 : 2'd0};
    vecs[5] = '{1,1,0,4'h5,8'h00,8'h00,15'h0000,0,0,2'd0, 0,8'h00,15'h6500,15'h0000,0,0,2'd0};

    // Reset held with inputs toggling
    reset_n = 0; pll_lock_i = 0; idle();
    for (int i = 0; i < 3; i++) begin
      bus_cs_n_i = 0; bus_rd_nwr_i = 1; bus_reg_num_i = 4'($urandom);
      bus_data_pad_i = 8'($urandom); vid_r_i = 4'($urandom); vid_hs_i = 1;
      bus_intr_i = 1; reconfig_i = 1; boot_select_i = 2'b11; pll_lock_i = 1;
      @(posedge clk); #1 chk_reset_vals("rst_hi");
      @(negedge clk); #1 chk_reset_vals("rst_lo");
    end

    // Release with lock held: core reset drops one edge later
    @(posedge clk); #1 idle(); pll_lock_i = 1; reset_n = 1;
    chk("crst_pre_edge", core_reset_o, 1);
    @(posedge clk); #1 chk("crst_release", core_reset_o, 0);
    pll_lock_i = 0;
    chk("crst_lock_drop_pre", core_reset_o, 0);
    @(posedge clk); #1 chk("crst_lock_drop", core_reset_o, 1);
    pll_lock_i = 1;
    @(posedge clk); #1 chk("crst_relock", core_reset_o, 0);

    // Read strobe: oe follows one cycle after cs_n
    bus_cs_n_i = 0; bus_rd_nwr_i = 1; bus_reg_num_i = 4'hA; core_data_i = 8'h5C;
    #1 chk("oe_not_yet", bus_data_oe_o, 0);
    chk("pad_o_comb", bus_data_pad_o, 8'h5C);
    @(posedge clk); #1 chk("oe_rise", bus_data_oe_o, 1);
    chk("regnum_a", core_reg_num_o, 4'hA);
    bus_cs_n_i = 1;
    #1 chk("oe_hold", bus_data_oe_o, 1);
    @(posedge clk); #1 chk("oe_fall", bus_data_oe_o, 0);

    // DDR pixel clock phase
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1 chk("idck_high_phase", dv_idck_o, 0);
      @(negedge clk); #1 chk("idck_low_phase", dv_idck_o, 1);
    end

    // Vector table
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 apply(vecs[i]);
      @(posedge clk); #1;
      chk($sformatf("v%0d_oe", i), bus_data_oe_o, vecs[i].ex_oe);
      chk($sformatf("v%0d_pad", i), bus_data_pad_o, vecs[i].ex_pad);
      chk($sformatf("v%0d_core", i),
          {core_cs_n_o, core_rd_nwr_o, core_bytesel_o, core_reg_num_o, core_data_o}, vecs[i].ex_core);
      chk($sformatf("v%0d_vid", i),
          {dv_de_o, dv_vs_o, dv_hs_o, dv_r_o, dv_g_o, dv_b_o}, vecs[i].ex_vid);
      chk($sformatf("v%0d_irq", i), bus_irq_n_o, vecs[i].ex_irq);
      chk($sformatf("v%0d_wb", i), {warmboot_o, boot_sel_o}, {vecs[i].ex_wb, vecs[i].ex_bsel});
    end

    // Warm-boot level held across cycles
    reconfig_i = 1; boot_select_i = 2'b10;
    @(posedge clk); #1 chk("wb_set", {warmboot_o, boot_sel_o}, WB ? 3'b110 : 3'b000);
    @(posedge clk); #1 chk("wb_held", {warmboot_o, boot_sel_o}, WB ? 3'b110 : 3'b000);
    reconfig_i = 0; boot_select_i = 2'b00;
    @(posedge clk); #1 chk("wb_clr", {warmboot_o, boot_sel_o}, 0);

    // Mid-transfer reset forces oe low without waiting for an edge
    bus_cs_n_i = 0; bus_rd_nwr_i = 1;
    @(posedge clk); #1 chk("mid_oe_on", bus_data_oe_o, 1);
    #2 reset_n = 0;
    #1 chk("mid_oe_off", bus_data_oe_o, 0);
    chk("mid_crst", core_reset_o, 1);
    @(negedge clk); #1 chk("mid_idck", dv_idck_o, 0);
    reset_n = 1; idle();
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
